store_monitor: RTL and testbench

Synthesizable store monitor sitting directly downstream of `single_cycle`, consuming its data-memory write port (`MemWrite`, `DataAdr`, `WriteData`) and `PC`.
- Classifies every store against a pass/allowed/fail rule, enforces a cycle timeout, and logs each store into a FIFO for post-run readout.
- Replaces the negedge `$display` checking in the bench with a clock-synchronous verdict usable in simulation and on FPGA.

---
 rtl/store_monitor.sv | 89 ++++++++
 tb/tb_store_monitor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/store_monitor.sv
// store_monitor: classifies single_cycle stores into a pass/fail/timeout verdict and logs them in a FIFO.
module store_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] ALLOW_ADDR     = 32'd96,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          LOG_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [31:0] PC,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [15:0] store_count,
  output logic [31:0] cycle_count,
  input  logic        log_rd_en,
  output logic        log_valid,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_empty,
  output logic        log_full,
  output logic        log_overflow
);
  localparam int AW = $clog2(LOG_DEPTH);
  typedef enum logic [1:0] {RUN, PASSED, FAILED, TIMED_OUT} state_t;
  state_t      r_state;
  logic [AW:0] r_wp, r_rp;
  logic [95:0] r_mem [LOG_DEPTH];
  logic        w_acc, w_pass, w_fail, w_tmo, w_pop, w_push;
  assign w_acc     = MemWrite && r_state == RUN;
  assign w_pass    = w_acc && DataAdr == PASS_ADDR && WriteData == PASS_DATA;
  assign w_fail    = w_acc && !w_pass && DataAdr != ALLOW_ADDR;
  assign w_tmo     = r_state == RUN && cycle_count == 32'(TIMEOUT_CYCLES - 1) && !w_pass && !w_fail;
  assign log_empty = r_wp == r_rp;
  assign log_full  = r_wp[AW] != r_rp[AW] && r_wp[AW-1:0] == r_rp[AW-1:0];
  assign w_pop     = log_rd_en && !log_empty;
  // a full log still accepts a store when the same edge frees a slot
  assign w_push    = w_acc && (!log_full || w_pop);
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= RUN;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      store_count  <= '0;
      cycle_count  <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
      log_valid    <= 1'b0;
      log_pc       <= '0;
      log_addr     <= '0;
      log_data     <= '0;
      log_overflow <= 1'b0;
      for (int i = 0; i < LOG_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_pass) begin
        r_state <= PASSED;
        done    <= 1'b1;
        pass    <= 1'b1;
      end else if (w_fail) begin
        r_state <= FAILED;
        done    <= 1'b1;
        fail    <= 1'b1;
      end else if (w_tmo) begin
        r_state <= TIMED_OUT;
        done    <= 1'b1;
        timeout <= 1'b1;
      end else if (r_state == RUN) cycle_count <= cycle_count + 32'd1;
      if (w_acc && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
      if (w_acc && !w_push) log_overflow <= 1'b1;
      if (w_push) begin
        r_mem[r_wp[AW-1:0]] <= {PC, DataAdr, WriteData};
        r_wp                <= r_wp + 1'b1;
      end
      log_valid <= w_pop;
      if (w_pop) begin
        {log_pc, log_addr, log_data} <= r_mem[r_rp[AW-1:0]];
        r_rp                         <= r_rp + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: directed checks of verdicts, timeout boundary, log FIFO and reset behaviour.
module tb_store_monitor;
  logic        clk = 0, Reset = 0, MemWrite = 0, log_rd_en = 0;
  logic [31:0] DataAdr = 0, WriteData = 0, PC = 0;
  logic        done, pass, fail, timeout, log_valid, log_empty, log_full, log_overflow;
  logic [15:0] store_count;
  logic [31:0] cycle_count, log_pc, log_addr, log_data;
  int tests = 0, fails = 0;
  store_monitor #(.TIMEOUT_CYCLES(20), .LOG_DEPTH(4)) dut (
    .clk(clk), .Reset(Reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData), .PC(PC),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .store_count(store_count),
    .cycle_count(cycle_count), .log_rd_en(log_rd_en), .log_valid(log_valid), .log_pc(log_pc),
    .log_addr(log_addr), .log_data(log_data), .log_empty(log_empty), .log_full(log_full),
    .log_overflow(log_overflow)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic we, input logic [31:0] pc, a, d, input logic rd);
    MemWrite = we; PC = pc; DataAdr = a; WriteData = d; log_rd_en = rd;
    @(negedge clk);
    MemWrite = 0; log_rd_en = 0;
  endtask
  task automatic do_reset();
    Reset = 0; MemWrite = 0; log_rd_en = 0;
    @(negedge clk);
    @(negedge clk);
    Reset = 1;
  endtask
  task automatic chk_verdict(input string name, input logic [3:0] exp, input logic [15:0] sc);
    tests++;
    if ({done, pass, fail, timeout, store_count} !== {exp, sc}) begin
      fails++;
      $display("FAIL %s: dpft=%b count=%0d, want dpft=%b count=%0d", name, {done, pass, fail, timeout}, store_count, exp, sc);
    end
  endtask
  task automatic chk_pop(input string name, input logic [31:0] pc, a, d);
    cyc(0, 0, 0, 0, 1);
    tests++;
    if ({log_valid, log_pc, log_addr, log_data} !== {1'b1, pc, a, d}) begin
      fails++;
      $display("FAIL %s: v=%b %h/%h/%h, want v=1 %h/%h/%h", name, log_valid, log_pc, log_addr, log_data, pc, a, d);
    end
  endtask
  task automatic chk_fifo(input string name, input logic [2:0] exp);
    tests++;
    if ({log_empty, log_full, log_overflow} !== exp) begin
      fails++;
      $display("FAIL %s: empty/full/ovf=%b, want %b", name, {log_empty, log_full, log_overflow}, exp);
    end
  endtask
  task automatic test_reset();
    Reset = 0;
    #1;
    tests++;
    if ({done, pass, fail, timeout, store_count, cycle_count, log_valid, log_pc, log_addr, log_data,
         log_empty, log_full, log_overflow} !== {4'b0, 16'd0, 32'd0, 1'b0, 96'd0, 3'b100}) begin
      fails++;
      $display("FAIL reset_values: done=%b cnt=%0d cyc=%0d v=%b empty=%b full=%b ovf=%b",
               done, store_count, cycle_count, log_valid, log_empty, log_full, log_overflow);
    end
    @(negedge clk);
    Reset = 1;
  endtask
  task automatic test_pass();
    do_reset();
    cyc(1, 32'h10, 96, 5, 0);
    chk_verdict("pass_allow", 4'b0000, 1);
    cyc(1, 32'h14, 100, 7, 0);
    chk_verdict("pass_verdict", 4'b1100, 2);
    chk_pop("pass_log0", 32'h10, 96, 5);
    chk_pop("pass_log1", 32'h14, 100, 7);
    chk_fifo("pass_drained", 3'b100);
    cyc(0, 0, 0, 0, 1);
    tests++;
    if ({log_valid, log_data} !== {1'b0, 32'd7}) begin
      fails++;
      $display("FAIL pop_empty: v=%b data=%0d, want v=0 data=7", log_valid, log_data);
    end
  endtask
  task automatic test_fail();
    do_reset();
    cyc(1, 32'h20, 100, 6, 0);
    chk_verdict("fail_verdict", 4'b1010, 1);
    cyc(1, 32'h24, 100, 7, 0);
    chk_verdict("fail_ignore", 4'b1010, 1);
    chk_pop("fail_log0", 32'h20, 100, 6);
    chk_fifo("fail_one_entry", 3'b100);
  endtask
  task automatic test_timeout();
    do_reset();
    repeat (19) @(negedge clk);
    chk_verdict("tmo_before", 4'b0000, 0);
    tests++;
    if (cycle_count !== 32'd19) begin
      fails++;
      $display("FAIL tmo_cycles19: got %0d want 19", cycle_count);
    end
    @(negedge clk);
    chk_verdict("tmo_verdict", 4'b1001, 0);
    repeat (3) @(negedge clk);
    tests++;
    if (cycle_count !== 32'd19) begin
      fails++;
      $display("FAIL tmo_frozen: got %0d want 19", cycle_count);
    end
  endtask
  task automatic test_boundary();
    do_reset();
    repeat (19) @(negedge clk);
    cyc(1, 32'h30, 100, 7, 0);
    chk_verdict("limit_pass_wins", 4'b1100, 1);
    do_reset();
    repeat (19) @(negedge clk);
    cyc(1, 32'h34, 96, 1, 0);
    chk_verdict("limit_allow_tmo", 4'b1001, 1);
  endtask
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 4 * i, 96, i, 0);
    chk_fifo("ovf_full4", 3'b010);
    for (int i = 4; i < 6; i++) cyc(1, 32'h100 + 4 * i, 96, i, 0);
    chk_fifo("ovf_set", 3'b011);
    chk_verdict("ovf_count", 4'b0000, 6);
    for (int i = 0; i < 4; i++) chk_pop($sformatf("ovf_log%0d", i), 32'h100 + 4 * i, 96, i);
    chk_fifo("ovf_drained", 3'b101);
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 32'h200 + 4 * i, 96, 10 + i, 0);
    cyc(1, 32'h210, 96, 14, 1);
    tests++;
    if ({log_valid, log_data} !== {1'b1, 32'd10}) begin
      fails++;
      $display("FAIL full_pushpop_pop: v=%b data=%0d, want v=1 data=10", log_valid, log_data);
    end
    chk_fifo("full_pushpop", 3'b010);
    for (int i = 1; i < 5; i++) chk_pop($sformatf("full_pushpop_log%0d", i), 32'h200 + 4 * i, 96, 10 + i);
    chk_fifo("full_pushpop_drained", 3'b100);
    do_reset();
    cyc(1, 32'h300, 96, 9, 1);
    tests++;
    if ({log_valid, log_empty} !== 2'b00) begin
      fails++;
      $display("FAIL empty_pushpop: v=%b empty=%b, want v=0 empty=0", log_valid, log_empty);
    end
    chk_pop("empty_pushpop_log", 32'h300, 96, 9);
  endtask
  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 32'h400 + 4 * i, 96, 20 + i, 0);
    chk_pop("mid_pre_pop", 32'h400, 96, 20);
    Reset = 0;
    #1;
    tests++;
    if ({done, store_count, cycle_count, log_valid, log_pc, log_data, log_empty, log_full, log_overflow}
        !== {1'b0, 16'd0, 32'd0, 1'b0, 64'd0, 3'b100}) begin
      fails++;
      $display("FAIL mid_reset: done=%b cnt=%0d cyc=%0d v=%b pc=%h data=%h empty=%b",
               done, store_count, cycle_count, log_valid, log_pc, log_data, log_empty);
    end
    @(negedge clk);
    Reset = 1;
    cyc(1, 32'h500, 100, 7, 0);
    chk_verdict("mid_restart", 4'b1100, 1);
    chk_pop("mid_restart_log", 32'h500, 100, 7);
    chk_fifo("mid_restart_empty", 3'b100);
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_boundary();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
